// File: rtl/nvdla_rws_fifo_ctl.sv
`timescale 1ns/1ps
// Valid/ready FIFO controller for an external 64x128 two-port RAM with a registered read address.
// Prefetches through the read port so that downstream sees one word per cycle.
module nvdla_rws_fifo_ctl (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         in_pvld,
    output logic         in_prdy,
    input  logic [127:0] in_pd,
    output logic         out_pvld,
    input  logic         out_prdy,
    output logic [127:0] out_pd,
    output logic [5:0]   ram_wa,
    output logic         ram_we,
    output logic [127:0] ram_di,
    output logic [5:0]   ram_ra,
    output logic         ram_re,
    input  logic [127:0] ram_dout,
    input  logic [31:0]  pwrbus_ram_pd,
    output logic [31:0]  ram_pwrbus_ram_pd,
    output logic [6:0]   fifo_count
);

    localparam int unsigned AW    = 6;
    localparam int unsigned CW    = 7;
    localparam int unsigned DEPTH = 64;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_pend;
    logic          r_out_pvld;
    logic          r_in_prdy;

    logic          w_push;
    logic          w_pop;
    logic          w_fetch;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_pend_nxt;
    logic          w_out_pvld_nxt;
    logic          w_in_prdy_nxt;

    // Handshakes, prefetch decision and next-state values.
    always_comb begin
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_fetch        = 1'b0;
        w_count_nxt    = r_count;
        w_pend_nxt     = r_pend;
        w_out_pvld_nxt = r_out_pvld;
        w_in_prdy_nxt  = r_in_prdy;

        w_push  = in_pvld & r_in_prdy;
        w_pop   = r_out_pvld & out_prdy;
        // Load the output slot only when it is empty or being drained this cycle.
        w_fetch = (r_pend != '0) & (~r_out_pvld | out_prdy);

        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        w_pend_nxt  = r_pend + CW'(w_push) - CW'(w_fetch);

        if (w_fetch) begin
            w_out_pvld_nxt = 1'b1;
        end else if (w_pop) begin
            w_out_pvld_nxt = 1'b0;
        end

        // Ready is based on next occupancy, so a pop at full frees the slot one cycle later.
        w_in_prdy_nxt = (w_count_nxt != CW'(DEPTH));
    end

    // Pointer, occupancy and handshake registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_out_pvld <= 1'b0;
            r_in_prdy  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_pend     <= w_pend_nxt;
            r_out_pvld <= w_out_pvld_nxt;
            r_in_prdy  <= w_in_prdy_nxt;
        end
    end

    // RAM port drive; read data flows straight out since the RAM holds its address on re=0.
    assign in_prdy           = r_in_prdy;
    assign out_pvld          = r_out_pvld;
    assign out_pd            = ram_dout;
    assign ram_wa            = r_wr_ptr;
    assign ram_we            = w_push;
    assign ram_di            = in_pd;
    assign ram_ra            = r_rd_ptr;
    assign ram_re            = w_fetch;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
    assign fifo_count        = r_count;

endmodule

// File: tb/tb_nvdla_rws_fifo_ctl.sv
`timescale 1ns/1ps
// Bench for nvdla_rws_fifo_ctl: attached RAM, queue-based reference model, vector table and corner sequences.
module tb_nvdla_rws_fifo_ctl;

    logic         clk;
    logic         rst_n;
    logic         in_pvld;
    logic         in_prdy;
    logic [127:0] in_pd;
    logic         out_pvld;
    logic         out_prdy;
    logic [127:0] out_pd;
    logic [5:0]   ram_wa;
    logic         ram_we;
    logic [127:0] ram_di;
    logic [5:0]   ram_ra;
    logic         ram_re;
    logic [127:0] ram_dout;
    logic [31:0]  pwrbus;
    logic [31:0]  ram_pwrbus;
    logic [6:0]   fifo_count;

    int checks = 0;
    int errors = 0;

    nvdla_rws_fifo_ctl dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rst_n),
        .in_pvld           (in_pvld),
        .in_prdy           (in_prdy),
        .in_pd             (in_pd),
        .out_pvld          (out_pvld),
        .out_prdy          (out_prdy),
        .out_pd            (out_pd),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus),
        .ram_pwrbus_ram_pd (ram_pwrbus),
        .fifo_count        (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port RAM: synchronous write, registered read address, combinational read data.
    logic [127:0] mem [64];
    logic [5:0]   ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: words written but not yet on the output, plus the presented word.
    logic [127:0] m_pend [$];
    logic         m_vld;
    logic [127:0] m_word;
    logic         m_rdy;
    logic [5:0]   m_nwr;
    logic [5:0]   m_nrd;

    function automatic int m_occ();
        return m_pend.size() + (m_vld ? 1 : 0);
    endfunction

    always @(negedge clk or negedge rst_n) begin
        logic push, pop, fetch;
        if (!rst_n) begin
            m_pend.delete();
            m_vld  = 1'b0;
            m_word = '0;
            m_rdy  = 1'b0;
            m_nwr  = '0;
            m_nrd  = '0;
        end
        if (!clk) begin
            push  = in_pvld & m_rdy;
            pop   = m_vld & out_prdy;
            fetch = (m_pend.size() != 0) && (!m_vld || out_prdy);
            chk("m_in_prdy", in_prdy, m_rdy);
            chk("m_out_pvld", out_pvld, m_vld);
            chk("m_count", fifo_count, 128'(m_occ()));
            chk("m_ram_we", ram_we, push);
            chk("m_ram_re", ram_re, fetch);
            chk("m_ram_wa", ram_wa, m_nwr);
            chk("m_ram_ra", ram_ra, m_nrd);
            chk("m_pwrbus", ram_pwrbus, pwrbus);
            if (m_vld) chk("m_out_pd", out_pd, m_word);
            if (rst_n) begin
                if (fetch) begin
                    m_word = m_pend.pop_front();
                    m_vld  = 1'b1;
                    m_nrd  = m_nrd + 6'd1;
                end else if (pop) begin
                    m_vld = 1'b0;
                end
                if (push) begin
                    m_pend.push_back(in_pd);
                    m_nwr = m_nwr + 6'd1;
                end
                m_rdy = (m_occ() != 64);
            end
        end
    end

    typedef struct {
        logic         pv;
        logic         pr;
        logic [127:0] pd;
        logic         e_rdy;
        logic         e_vld;
        logic [6:0]   e_cnt;
        logic         e_we;
        logic         e_re;
        logic [5:0]   e_wa;
        logic [5:0]   e_ra;
        logic         pd_chk;
    } vec_t;

    localparam logic [127:0] WORD_A5 = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_0001;
    vec_t tbl [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_pvld  = 1'b0;
        out_prdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (m_occ() == 0 && !ram_re) break;
            tick();
        end
        @(negedge clk);
        chk("drain_empty", fifo_count, 0);
        tick();
    endtask

    initial begin
        logic [127:0] base;
        logic         seen;
        rst_n    = 1'b0;
        in_pvld  = 1'b0;
        out_prdy = 1'b0;
        in_pd    = '0;
        pwrbus   = 32'h1234_5678;

        // Row 0: just after release, before any edge; rows 1-10 idle; rows 11-14 single push.
        tbl[0] = '{1'b0, 1'b1, '0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0};
        for (int i = 1; i <= 10; i++)
            tbl[i] = '{1'b0, 1'b1, '0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, WORD_A5, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, '0,      1'b1, 1'b0, 7'd1, 1'b0, 1'b1, 6'd1, 6'd0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, '0,      1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 6'd1, 6'd1, 1'b1};
        tbl[14] = '{1'b0, 1'b1, '0,      1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 6'd1, 6'd1, 1'b0};

        repeat (3) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            in_pvld  = tbl[i].pv;
            out_prdy = tbl[i].pr;
            in_pd    = tbl[i].pd;
            @(negedge clk);
            chk($sformatf("v%0d_in_prdy", i), in_prdy, tbl[i].e_rdy);
            chk($sformatf("v%0d_out_pvld", i), out_pvld, tbl[i].e_vld);
            chk($sformatf("v%0d_count", i), fifo_count, tbl[i].e_cnt);
            chk($sformatf("v%0d_we", i), ram_we, tbl[i].e_we);
            chk($sformatf("v%0d_re", i), ram_re, tbl[i].e_re);
            chk($sformatf("v%0d_wa", i), ram_wa, tbl[i].e_wa);
            chk($sformatf("v%0d_ra", i), ram_ra, tbl[i].e_ra);
            if (tbl[i].pd_chk) chk($sformatf("v%0d_out_pd", i), out_pd, WORD_A5);
            tick();
        end

        // Fill to 64 with the consumer stalled.
        base = 128'h1000;
        out_prdy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_pvld = 1'b1;
            in_pd   = base + 128'(i);
            @(negedge clk);
            chk("fill_in_prdy", in_prdy, 1);
            tick();
        end
        in_pd = 128'hDEAD;
        @(negedge clk);
        chk("full_in_prdy", in_prdy, 0);
        chk("full_count", fifo_count, 64);
        chk("full_refuse", ram_we, 0);
        tick();
        @(negedge clk);
        chk("full_hold", fifo_count, 64);
        tick();
        // Pop at full with in_pvld still high: push refused.
        out_prdy = 1'b1;
        @(negedge clk);
        chk("full_pop_pd", out_pd, base);
        chk("full_pop_we", ram_we, 0);
        tick();
        in_pd = 128'hBEEF;
        @(negedge clk);
        chk("reopen_in_prdy", in_prdy, 1);
        chk("reopen_count", fifo_count, 63);
        chk("reopen_pop_pd", out_pd, base + 128'd1);
        tick();
        in_pvld = 1'b0;
        @(negedge clk);
        chk("c63_push_pop", fifo_count, 63);
        chk("c63_in_prdy", in_prdy, 1);
        tick();
        drain();

        // Stream 200 words at full rate.
        base = 128'h2000;
        out_prdy = 1'b1;
        for (int k = 0; k < 202; k++) begin
            in_pvld = (k < 200);
            in_pd   = base + 128'(k);
            @(negedge clk);
            if (k >= 2) begin
                chk("stream_vld", out_pvld, 1);
                chk("stream_pd", out_pd, base + 128'(k - 2));
            end
            tick();
        end
        drain();

        // Random traffic: a back-pressured phase to reach full, then 50/50.
        for (int c = 0; c < 6000; c++) begin
            if (c < 1000) begin
                in_pvld  = ($urandom_range(3) != 0);
                out_prdy = ($urandom_range(3) == 0);
            end else begin
                in_pvld  = $urandom_range(1);
                out_prdy = $urandom_range(1);
            end
            in_pd = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(63) == 0) pwrbus = $urandom;
            tick();
        end
        drain();

        // Asynchronous reset with 10 entries held.
        out_prdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_pvld = 1'b1;
            in_pd   = 128'h3000 + 128'(i);
            tick();
        end
        in_pvld = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", fifo_count, 10);
        chk("pre_rst_vld", out_pvld, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", out_pvld, 0);
        chk("async_rst_count", fifo_count, 0);
        chk("async_rst_rdy", in_prdy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        out_prdy = 1'b1;
        in_pvld  = 1'b1;
        in_pd    = 128'h4444;
        tick();
        in_pd = 128'h4445;
        tick();
        in_pvld = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (out_pvld) begin
                chk("post_rst_first", out_pd, 128'h4444);
                seen = 1'b1;
            end
            tick();
        end
        chk("post_rst_seen", seen, 1);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
